// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: solid, colour bars, scrolling checkerboard, gradient,
// legacy green. Optional white frame border when PATTERN_BORDER_EN is defined.
module vga_pattern_gen #(
  parameter int unsigned COLOR_W    = 10,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST_N,
  input  logic [X_W-1:0]         iVGA_X,
  input  logic [Y_W-1:0]         iVGA_Y,
  input  logic [2:0]             iMode,
  input  logic [3*COLOR_W-1:0]   iSolid_RGB,
  input  logic                   iScroll_EN,
  output logic [COLOR_W-1:0]     oRed,
  output logic [COLOR_W-1:0]     oGreen,
  output logic [COLOR_W-1:0]     oBlue,
  output logic                   oFrame_Start,
  output logic [2:0]             oMode_Active
);

  localparam int unsigned BarW = H_ACTIVE / 8;
  localparam logic [COLOR_W-1:0] FullScale = '1;
  localparam logic [COLOR_W-1:0] LegacyGreen = {1'b1, {(COLOR_W-1){1'b0}}};

  logic                 frameStart;
  logic                 active;
  logic [2:0]           modeQ, modeCur;
  logic [X_W-1:0]       offsetQ, offsetD, xs;
  logic [2:0]           barIdx;
  logic [COLOR_W-1:0]   redD, greenD, blueD;
  logic [COLOR_W-1:0]   redQ, greenQ, blueQ;
  logic                 frameStartQ;

  assign frameStart = (iVGA_X == '0) && (iVGA_Y == '0);

  always_comb begin
    // The (0,0) pixel already uses the mode being latched in this cycle.
    modeCur = frameStart ? iMode : modeQ;
    offsetD = offsetQ;
    if (frameStart && iScroll_EN) offsetD = offsetQ + X_W'(1);
    xs = iVGA_X + offsetQ;
    active = (32'(iVGA_X) < H_ACTIVE) && (32'(iVGA_Y) < V_ACTIVE);

    barIdx = '0;
    for (int k = 1; k < 8; k++) begin
      if (32'(iVGA_X) >= k * BarW) barIdx = barIdx + 3'd1;
    end

    redD   = '0;
    greenD = '0;
    blueD  = '0;
    if (active) begin
      case (modeCur)
        3'd0: {redD, greenD, blueD} = iSolid_RGB;
        3'd1: begin
          // Bar order white..black maps to inverted index bits per channel.
          redD   = {COLOR_W{~barIdx[1]}};
          greenD = {COLOR_W{~barIdx[2]}};
          blueD  = {COLOR_W{~barIdx[0]}};
        end
        3'd2: begin
          if (xs[CHECK_LOG2] ^ iVGA_Y[CHECK_LOG2]) begin
            redD   = FullScale;
            greenD = FullScale;
            blueD  = FullScale;
          end
        end
        3'd3: begin
          redD   = COLOR_W'(iVGA_X);
          greenD = COLOR_W'(iVGA_Y);
          blueD  = COLOR_W'(xs);
        end
        3'd4: greenD = LegacyGreen;
        default: ;
      endcase
`ifdef PATTERN_BORDER_EN
      if ((iVGA_X == '0) || (32'(iVGA_X) == H_ACTIVE - 1) ||
          (iVGA_Y == '0) || (32'(iVGA_Y) == V_ACTIVE - 1)) begin
        redD   = FullScale;
        greenD = FullScale;
        blueD  = FullScale;
      end
`endif
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_N) begin
      modeQ       <= '0;
      offsetQ     <= '0;
      redQ        <= '0;
      greenQ      <= '0;
      blueQ       <= '0;
      frameStartQ <= 1'b0;
    end else begin
      modeQ       <= modeCur;
      offsetQ     <= offsetD;
      redQ        <= redD;
      greenQ      <= greenD;
      blueQ       <= blueD;
      frameStartQ <= frameStart;
    end
  end

  assign oRed         = redQ;
  assign oGreen       = greenQ;
  assign oBlue        = blueQ;
  assign oFrame_Start = frameStartQ;
  assign oMode_Active = modeQ;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed, table-driven bench for vga_pattern_gen at default parameters.
module tb_vga_pattern_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] mode;
    logic       scroll;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       fs;
    logic [2:0] ma;
  } vec_t;

  localparam logic [9:0] W = 10'd1023;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [9:0]  vgaX = '0;
  logic [9:0]  vgaY = '0;
  logic [2:0]  mode = '0;
  logic [29:0] solid = {10'd100, 10'd200, 10'd300};
  logic        scrollEn = 1'b0;
  logic [9:0]  red, green, blue;
  logic        frameStart;
  logic [2:0]  modeActive;

  int nApplied = 0;
  int nMiss = 0;
  int tag = 0;
  vec_t vecs[$];

  vga_pattern_gen dut (
    .iVGA_CLK     (clk),
    .iRST_N       (rstN),
    .iVGA_X       (vgaX),
    .iVGA_Y       (vgaY),
    .iMode        (mode),
    .iSolid_RGB   (solid),
    .iScroll_EN   (scrollEn),
    .oRed         (red),
    .oGreen       (green),
    .oBlue        (blue),
    .oFrame_Start (frameStart),
    .oMode_Active (modeActive)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int x, input int y, input int m, input int s,
                              input int r, input int g, input int b, input int fs,
                              input int ma);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.mode = 3'(m); v.scroll = 1'(s);
    v.r = 10'(r); v.g = 10'(g); v.b = 10'(b); v.fs = 1'(fs); v.ma = 3'(ma);
    return v;
  endfunction

  // Edge pixels of the active area turn white when the border option is built in.
  function automatic vec_t fixBorder(input vec_t v);
    vec_t o = v;
`ifdef PATTERN_BORDER_EN
    if (v.x < 640 && v.y < 480 && (v.x == 0 || v.x == 639 || v.y == 0 || v.y == 479)) begin
      o.r = W; o.g = W; o.b = W;
    end
`endif
    return o;
  endfunction

  task automatic applyCheck(input vec_t vIn);
    vec_t v;
    v = fixBorder(vIn);
    vgaX = v.x; vgaY = v.y; mode = v.mode; scrollEn = v.scroll;
    @(posedge clk);
    #1;
    nApplied++;
    if ({red, green, blue, frameStart, modeActive} !== {v.r, v.g, v.b, v.fs, v.ma}) begin
      nMiss++;
      $display("FAIL vec%0d (x=%0d,y=%0d): got rgb=(%0d,%0d,%0d) fs=%0d mode=%0d, want rgb=(%0d,%0d,%0d) fs=%0d mode=%0d",
               tag, v.x, v.y, red, green, blue, frameStart, modeActive,
               v.r, v.g, v.b, v.fs, v.ma);
    end
    tag++;
  endtask

  initial begin
    // Colour bars, mid-frame mode change, scrolling checker, mode switch, border pixels.
    vecs.push_back(mk(0, 0, 1, 0, W, W, W, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, W, W, W, 0, 1));
    vecs.push_back(mk(0, 10, 1, 0, W, W, W, 0, 1));
    vecs.push_back(mk(79, 10, 1, 0, W, W, W, 0, 1));
    vecs.push_back(mk(80, 10, 1, 0, W, W, 0, 0, 1));
    vecs.push_back(mk(159, 10, 1, 0, W, W, 0, 0, 1));
    vecs.push_back(mk(160, 10, 1, 0, 0, W, W, 0, 1));
    vecs.push_back(mk(240, 10, 1, 0, 0, W, 0, 0, 1));
    vecs.push_back(mk(320, 10, 1, 0, W, 0, W, 0, 1));
    vecs.push_back(mk(400, 10, 1, 0, W, 0, 0, 0, 1));
    vecs.push_back(mk(480, 10, 1, 0, 0, 0, W, 0, 1));
    vecs.push_back(mk(559, 10, 1, 0, 0, 0, W, 0, 1));
    vecs.push_back(mk(560, 10, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(639, 10, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(640, 10, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 480, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(100, 200, 2, 0, W, W, 0, 0, 1));
    vecs.push_back(mk(0, 0, 2, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(30, 0, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(33, 0, 2, 0, W, W, W, 0, 2));
    vecs.push_back(mk(30, 32, 2, 0, W, W, W, 0, 2));
    vecs.push_back(mk(0, 0, 2, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(30, 0, 2, 0, W, W, W, 0, 2));
    vecs.push_back(mk(62, 0, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(30, 32, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 2, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(30, 0, 2, 0, W, W, W, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 100, 200, 300, 1, 0));
    vecs.push_back(mk(100, 200, 4, 0, 100, 200, 300, 0, 0));
    vecs.push_back(mk(639, 479, 4, 0, 100, 200, 300, 0, 0));
    vecs.push_back(mk(0, 0, 4, 0, 0, 512, 0, 1, 4));
    vecs.push_back(mk(1, 0, 4, 0, 0, 512, 0, 0, 4));
    vecs.push_back(mk(640, 0, 4, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 5, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mk(200, 100, 5, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 6, 0, 0, 0, 0, 1, 6));
    vecs.push_back(mk(0, 100, 6, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(639, 100, 6, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(320, 479, 6, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(320, 240, 6, 0, 0, 0, 0, 0, 6));

    // Reset held two cycles with mode 1 requested, then release away from (0,0).
    applyCheck(mk(5, 5, 1, 0, 0, 0, 0, 0, 0));
    applyCheck(mk(5, 5, 1, 0, 0, 0, 0, 0, 0));
    rstN = 1'b1;
    applyCheck(mk(5, 5, 1, 0, 100, 200, 300, 0, 0));

    foreach (vecs[i]) applyCheck(vecs[i]);

    // Hold (0,0) so the offset climbs from 2 to 1022, then walk through the wrap.
    vgaX = '0; vgaY = '0; mode = 3'd3; scrollEn = 1'b1;
    repeat (1020) @(posedge clk);
    #1;
    applyCheck(mk(0, 0, 3, 1, 0, 0, 1022, 1, 3));
    applyCheck(mk(0, 0, 3, 1, 0, 0, 1023, 1, 3));
    applyCheck(mk(5, 7, 3, 0, 5, 7, 5, 0, 3));
    applyCheck(mk(600, 400, 3, 0, 600, 400, 600, 0, 3));
    applyCheck(mk(0, 0, 3, 1, 0, 0, 0, 1, 3));
    applyCheck(mk(50, 50, 3, 0, 50, 50, 51, 0, 3));

    // Mid-frame reset clears mode and offset.
    rstN = 1'b0;
    applyCheck(mk(50, 50, 3, 0, 0, 0, 0, 0, 0));
    rstN = 1'b1;
    applyCheck(mk(50, 50, 3, 0, 100, 200, 300, 0, 0));
    applyCheck(mk(0, 0, 2, 0, 0, 0, 0, 1, 2));
    applyCheck(mk(31, 1, 2, 0, 0, 0, 0, 0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
